// File: rtl/rf_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_seq_pkg
//  Description : Shared types and default widths for the register file
//                access sequencer (command opcodes, FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_seq_pkg;

   localparam int c_ADDR_W = 18;
   localparam int c_DATA_W = 32;
   localparam int c_LEN_W  = 8;

   // Command opcodes as they appear on req_op
   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_COPY  = 2'd2,
      OP_FILL  = 2'd3
   } op_t;

   // Sequencer states; IDLE is the only state that accepts commands
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COPY_WR = 2'd1,
      ST_FILL    = 2'd2
   } state_t;

endpackage : rf_seq_pkg
`default_nettype wire

// File: rtl/rf_rsp_slot.sv
`default_nettype none
// ============================================================================
//  Module      : rf_rsp_slot
//  Description : Single-entry read response holding register. Loads a pair
//                of data words and presents them with valid/ready; data is
//                held stable until the consumer takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_rsp_slot
   import rf_seq_pkg::*;
#(
   parameter int DATA_W = c_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_dat1,
   input  logic [DATA_W-1:0] i_dat2,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_dat1,
   output logic [DATA_W-1:0] o_dat2
);

   logic              r_valid;
   logic [DATA_W-1:0] r_dat1;
   logic [DATA_W-1:0] r_dat2;

   // Load wins over drain: a load is only ever issued when the slot is empty
   // or being consumed this cycle, so nothing unread is overwritten.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_dat1  <= '0;
         r_dat2  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_dat1  <= i_dat1;
         r_dat2  <= i_dat2;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_dat1  = r_dat1;
   assign o_dat2  = r_dat2;

endmodule : rf_rsp_slot
`default_nettype wire

// File: rtl/rf_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rf_access_sequencer
//  Description : Initiator-side controller for the register file. Executes
//                READ / WRITE / COPY / FILL commands, drives the register
//                file select/enable/data lines and returns read results on a
//                valid/ready response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_access_sequencer
   import rf_seq_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W,
   parameter int DATA_W = c_DATA_W,
   parameter int LEN_W  = c_LEN_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr_a,
   input  logic [ADDR_W-1:0] req_addr_b,
   input  logic [DATA_W-1:0] req_wdat,
   input  logic [LEN_W-1:0]  req_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdat1,
   output logic [DATA_W-1:0] rsp_rdat2,
   output logic              busy,
   output logic              rf_wen,
   output logic [ADDR_W-1:0] rf_wsel,
   output logic [ADDR_W-1:0] rf_rsel1,
   output logic [ADDR_W-1:0] rf_rsel2,
   output logic [DATA_W-1:0] rf_wdat,
   input  logic [DATA_W-1:0] rf_rdat1,
   input  logic [DATA_W-1:0] rf_rdat2
);

   state_t            r_state;
   state_t            w_next;
   op_t               w_op;
   logic              w_accept;
   logic              w_rd_load;
   // r_wptr is the COPY destination or the current FILL address;
   // r_wbuf is the COPY source data or the FILL pattern.
   logic [ADDR_W-1:0] r_wptr;
   logic [DATA_W-1:0] r_wbuf;
   logic [LEN_W-1:0]  r_cnt;

   assign w_op      = op_t'(req_op);
   // An unconsumed response blocks acceptance; one drained this cycle does not.
   assign req_ready = (r_state == ST_IDLE) && !(rsp_valid && !rsp_ready);
   assign w_accept  = req_valid && req_ready;
   assign w_rd_load = w_accept && (w_op == OP_READ);
   assign busy      = (r_state != ST_IDLE);

   // Read selects come straight from the command so read data is valid at the accept edge
   assign rf_rsel1 = req_addr_a;
   assign rf_rsel2 = req_addr_b;

   // State register
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && (w_op == OP_COPY)) begin
               w_next = ST_COPY_WR;
            end else if (w_accept && (w_op == OP_FILL) && (req_len != '0)) begin
               w_next = ST_FILL;
            end
         end
         ST_COPY_WR: w_next = ST_IDLE;
         ST_FILL: begin
            if (r_cnt == LEN_W'(1)) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Write pointer, write data buffer and fill counter
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_wptr <= '0;
         r_wbuf <= '0;
         r_cnt  <= '0;
      end else if (w_accept && (w_op == OP_COPY)) begin
         r_wptr <= req_addr_b;
         r_wbuf <= rf_rdat1;
      end else if (w_accept && (w_op == OP_FILL)) begin
         r_wptr <= req_addr_a;
         r_wbuf <= req_wdat;
         r_cnt  <= req_len;
      end else if (r_state == ST_FILL) begin
         // Natural ADDR_W-bit overflow gives the wrap past all-ones to zero
         r_wptr <= r_wptr + ADDR_W'(1);
         r_cnt  <= r_cnt - LEN_W'(1);
      end
   end

   // Register file write port drive
   always_comb begin
      rf_wen  = 1'b0;
      rf_wsel = req_addr_a;
      rf_wdat = req_wdat;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && (w_op == OP_WRITE)) begin
               rf_wen = 1'b1;
            end
         end
         ST_COPY_WR, ST_FILL: begin
            rf_wen  = 1'b1;
            rf_wsel = r_wptr;
            rf_wdat = r_wbuf;
         end
         default: rf_wen = 1'b0;
      endcase
      // Reset aborts any write in flight so nothing commits on the reset edge
      if (!nRST) begin
         rf_wen = 1'b0;
      end
   end

   rf_rsp_slot #(
      .DATA_W (DATA_W)
   ) u_rsp_slot (
      .clk     (CLK),
      .rst_n   (nRST),
      .i_load  (w_rd_load),
      .i_dat1  (rf_rdat1),
      .i_dat2  (rf_rdat2),
      .i_ready (rsp_ready),
      .o_valid (rsp_valid),
      .o_dat1  (rsp_rdat1),
      .o_dat2  (rsp_rdat2)
   );

endmodule : rf_access_sequencer
`default_nettype wire

// File: tb/tb_rf_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_access_sequencer
//  Description : Self-checking bench for rf_access_sequencer with an attached
//                register file and a command-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_access_sequencer;

   localparam int AW = 18;
   localparam int DW = 32;
   localparam int LW = 8;
   localparam int NREG = 1 << AW;

   logic          CLK;
   logic          nRST;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [AW-1:0] req_addr_a;
   logic [AW-1:0] req_addr_b;
   logic [DW-1:0] req_wdat;
   logic [LW-1:0] req_len;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdat1;
   logic [DW-1:0] rsp_rdat2;
   logic          busy;
   logic          rf_wen;
   logic [AW-1:0] rf_wsel;
   logic [AW-1:0] rf_rsel1;
   logic [AW-1:0] rf_rsel2;
   logic [DW-1:0] rf_wdat;
   logic [DW-1:0] rf_rdat1;
   logic [DW-1:0] rf_rdat2;

   int checks = 0;
   int errors = 0;

   rf_access_sequencer #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .LEN_W  (LW)
   ) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr_a (req_addr_a),
      .req_addr_b (req_addr_b),
      .req_wdat   (req_wdat),
      .req_len    (req_len),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdat1  (rsp_rdat1),
      .rsp_rdat2  (rsp_rdat2),
      .busy       (busy),
      .rf_wen     (rf_wen),
      .rf_wsel    (rf_wsel),
      .rf_rsel1   (rf_rsel1),
      .rf_rsel2   (rf_rsel2),
      .rf_wdat    (rf_wdat),
      .rf_rdat1   (rf_rdat1),
      .rf_rdat2   (rf_rdat2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Register file: combinational read, write commits at the rising edge
   logic [DW-1:0] rf_mem [0:NREG-1];
   logic          rf_init;
   assign rf_rdat1 = rf_mem[rf_rsel1];
   assign rf_rdat2 = rf_mem[rf_rsel2];

   always @(posedge CLK) begin
      if (rf_init) begin
         for (int i = 0; i < NREG; i++) rf_mem[i] <= '0;
      end else if (rf_wen) begin
         rf_mem[rf_wsel] <= rf_wdat;
      end
   end

   // Reference model: whole-command effects on an address->value map
   logic [DW-1:0] model_mem [logic [AW-1:0]];

   function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
      if (model_mem.exists(a)) return model_mem[a];
      return '0;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, input logic [DW-1:0] d, input logic [LW-1:0] l);
      req_valid  = v;
      req_op     = op;
      req_addr_a = a;
      req_addr_b = b;
      req_wdat   = d;
      req_len    = l;
   endtask

   task automatic test_reset();
      drive(1'b0, 2'd0, '0, '0, '0, '0);
      rsp_ready = 1'b1;
      nRST = 1'b0;
      #3;
      checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rst_wen_during got %b exp 0", rf_wen); end
      tick();
      nRST = 1'b1;
      #3;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_rdat1 !== '0 || rsp_rdat2 !== '0) begin errors++; $display("FAIL rst_rsp_data got %h/%h exp 0/0", rsp_rdat1, rsp_rdat2); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
      checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL rst_wen got %b exp 0", rf_wen); end
      tick();
   endtask

   task automatic test_write_read();
      rsp_ready = 1'b1;
      drive(1'b1, 2'd1, 18'h00005, '0, 32'hDEADBEEF, '0);
      #3;
      checks++; if (rf_wen !== 1'b1 || rf_wsel !== 18'h00005 || rf_wdat !== 32'hDEADBEEF)
         begin errors++; $display("FAIL wr_port got wen=%b sel=%h dat=%h exp 1/00005/deadbeef", rf_wen, rf_wsel, rf_wdat); end
      tick();
      drive(1'b1, 2'd0, 18'h00005, 18'h00000, '0, '0);
      #3;
      checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL wr_one_cycle got wen=%b exp 0", rf_wen); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_no_rsp got %b exp 0", rsp_valid); end
      tick();
      drive(1'b0, 2'd0, '0, '0, '0, '0);
      #3;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdat1 !== 32'hDEADBEEF || rsp_rdat2 !== 32'h0)
         begin errors++; $display("FAIL rd_after_wr got v=%b %h/%h exp 1 deadbeef/00000000", rsp_valid, rsp_rdat1, rsp_rdat2); end
      tick();
      #3;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_clear got %b exp 0", rsp_valid); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] ra [3];
      logic [AW-1:0] rb [3];
      logic [DW-1:0] e1 [3];
      logic [DW-1:0] e2 [3];
      ra[0] = 18'h5; rb[0] = 18'h0; e1[0] = 32'hDEADBEEF; e2[0] = 32'h0;
      ra[1] = 18'h0; rb[1] = 18'h5; e1[1] = 32'h0;        e2[1] = 32'hDEADBEEF;
      ra[2] = 18'h5; rb[2] = 18'h5; e1[2] = 32'hDEADBEEF; e2[2] = 32'hDEADBEEF;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(1'b1, 2'd0, ra[i], rb[i], '0, '0);
         else       drive(1'b0, 2'd0, '0, '0, '0, '0);
         #3;
         if (i < 3) begin
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, req_ready); end
         end
         if (i >= 1) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_rdat1 !== e1[i-1] || rsp_rdat2 !== e2[i-1])
               begin errors++; $display("FAIL b2b_rsp[%0d] got v=%b %h/%h exp 1 %h/%h", i-1, rsp_valid, rsp_rdat1, rsp_rdat2, e1[i-1], e2[i-1]); end
         end
         tick();
      end
      // Back-pressure: response held for two cycles
      drive(1'b1, 2'd0, 18'h0, 18'h5, '0, '0);
      tick();
      drive(1'b1, 2'd0, 18'h5, 18'h5, '0, '0);
      rsp_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #3;
         checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0", i, req_ready); end
         checks++; if (rsp_valid !== 1'b1 || rsp_rdat1 !== 32'h0 || rsp_rdat2 !== 32'hDEADBEEF)
            begin errors++; $display("FAIL stall_hold[%0d] got v=%b %h/%h exp 1 00000000/deadbeef", i, rsp_valid, rsp_rdat1, rsp_rdat2); end
         tick();
      end
      rsp_ready = 1'b1;
      #3;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_resume got %b exp 1", req_ready); end
      tick();
      drive(1'b0, 2'd0, '0, '0, '0, '0);
      #3;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdat1 !== 32'hDEADBEEF || rsp_rdat2 !== 32'hDEADBEEF)
         begin errors++; $display("FAIL stall_next got v=%b %h/%h exp 1 deadbeef/deadbeef", rsp_valid, rsp_rdat1, rsp_rdat2); end
      tick();
   endtask

   task automatic test_copy();
      rsp_ready = 1'b1;
      drive(1'b1, 2'd2, 18'h00005, 18'h00010, '0, '0);
      #3;
      checks++; if (req_ready !== 1'b1 || rf_wen !== 1'b0) begin errors++; $display("FAIL copy_accept got rdy=%b wen=%b exp 1/0", req_ready, rf_wen); end
      tick();
      drive(1'b1, 2'd0, 18'h00010, 18'h00005, '0, '0);
      #3;
      checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL copy_busy got busy=%b rdy=%b exp 1/0", busy, req_ready); end
      checks++; if (rf_wen !== 1'b1 || rf_wsel !== 18'h00010 || rf_wdat !== 32'hDEADBEEF)
         begin errors++; $display("FAIL copy_wr got wen=%b sel=%h dat=%h exp 1/00010/deadbeef", rf_wen, rf_wsel, rf_wdat); end
      tick();
      #3;
      checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL copy_done got busy=%b rdy=%b exp 0/1", busy, req_ready); end
      tick();
      drive(1'b0, 2'd0, '0, '0, '0, '0);
      #3;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdat1 !== 32'hDEADBEEF || rsp_rdat2 !== 32'hDEADBEEF)
         begin errors++; $display("FAIL copy_read got v=%b %h/%h exp 1 deadbeef/deadbeef", rsp_valid, rsp_rdat1, rsp_rdat2); end
      tick();
   endtask

   task automatic test_fill();
      logic [AW-1:0] exp_sel [4];
      exp_sel[0] = 18'h3FFFE; exp_sel[1] = 18'h3FFFF; exp_sel[2] = 18'h00000; exp_sel[3] = 18'h00001;
      rsp_ready = 1'b1;
      drive(1'b1, 2'd3, 18'h3FFFE, '0, 32'h12345678, 8'd4);
      #3;
      checks++; if (req_ready !== 1'b1 || rf_wen !== 1'b0) begin errors++; $display("FAIL fill_accept got rdy=%b wen=%b exp 1/0", req_ready, rf_wen); end
      tick();
      drive(1'b0, 2'd0, '0, '0, '0, '0);
      for (int k = 0; k < 4; k++) begin
         #3;
         checks++; if (rf_wen !== 1'b1 || busy !== 1'b1 || rf_wsel !== exp_sel[k] || rf_wdat !== 32'h12345678)
            begin errors++; $display("FAIL fill_step[%0d] got wen=%b busy=%b sel=%h dat=%h exp 1/1/%h/12345678", k, rf_wen, busy, rf_wsel, rf_wdat, exp_sel[k]); end
         tick();
      end
      #3;
      checks++; if (rf_wen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fill_end got wen=%b busy=%b exp 0/0", rf_wen, busy); end
      tick();
      drive(1'b1, 2'd3, 18'h00002, '0, 32'hFFFFFFFF, 8'd0);
      #3;
      checks++; if (req_ready !== 1'b1 || rf_wen !== 1'b0) begin errors++; $display("FAIL fill0_accept got rdy=%b wen=%b exp 1/0", req_ready, rf_wen); end
      tick();
      drive(1'b1, 2'd0, 18'h00001, 18'h00002, '0, '0);
      #3;
      checks++; if (rf_wen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fill0_idle got wen=%b busy=%b exp 0/0", rf_wen, busy); end
      tick();
      drive(1'b0, 2'd0, '0, '0, '0, '0);
      #3;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdat1 !== 32'h12345678 || rsp_rdat2 !== 32'h0)
         begin errors++; $display("FAIL fill_readback got v=%b %h/%h exp 1 12345678/00000000", rsp_valid, rsp_rdat1, rsp_rdat2); end
      tick();
   endtask

   task automatic test_reset_mid_fill();
      rsp_ready = 1'b1;
      drive(1'b1, 2'd3, 18'h00100, '0, 32'hA5A5A5A5, 8'd10);
      tick();
      drive(1'b0, 2'd0, '0, '0, '0, '0);
      tick();
      nRST = 1'b0;
      #3;
      checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL abort_wen_now got %b exp 0", rf_wen); end
      tick();
      #3;
      checks++; if (rf_wen !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0)
         begin errors++; $display("FAIL abort_state got wen=%b busy=%b rsp=%b exp 0/0/0", rf_wen, busy, rsp_valid); end
      tick();
      nRST = 1'b1;
      #3;
      checks++; if (rf_wen !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_after got wen=%b busy=%b exp 0/0", rf_wen, busy); end
      tick();
      drive(1'b1, 2'd0, 18'h00100, 18'h00101, '0, '0);
      tick();
      drive(1'b0, 2'd0, '0, '0, '0, '0);
      #3;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdat1 !== 32'hA5A5A5A5 || rsp_rdat2 !== 32'h0)
         begin errors++; $display("FAIL abort_readback got v=%b %h/%h exp 1 a5a5a5a5/00000000", rsp_valid, rsp_rdat1, rsp_rdat2); end
      tick();
   endtask

   task automatic test_random();
      localparam int NCMD   = 2000;
      localparam int BUDGET = 40000;
      logic [2*DW-1:0] exp_rsp [$];
      logic [AW+DW-1:0] exp_wr [$];
      logic [AW+DW-1:0] wr_got;
      logic [2*DW-1:0]  rsp_got;
      logic          have_cmd;
      logic [1:0]    c_op;
      logic [AW-1:0] c_a, c_b;
      logic [DW-1:0] c_d, v;
      logic [LW-1:0] c_l;
      int issued, accepted, cyc;
      issued = 0; accepted = 0; cyc = 0; have_cmd = 1'b0;
      c_op = '0; c_a = '0; c_b = '0; c_d = '0; c_l = '0;
      while ((accepted < NCMD || exp_rsp.size() > 0 || exp_wr.size() > 0) && cyc < BUDGET) begin
         if (!have_cmd && issued < NCMD) begin
            c_op = 2'($urandom_range(0, 3));
            c_a  = AW'(18'h20000 + $urandom_range(0, 63));
            c_b  = AW'(18'h20000 + $urandom_range(0, 63));
            c_d  = $urandom;
            c_l  = LW'($urandom_range(0, 8));
            have_cmd = 1'b1;
            issued++;
         end
         drive(have_cmd, c_op, c_a, c_b, c_d, c_l);
         rsp_ready = ($urandom_range(0, 3) != 0);
         #3;
         if (req_valid && req_ready) begin
            case (c_op)
               2'd0: exp_rsp.push_back({mread(c_a), mread(c_b)});
               2'd1: begin model_mem[c_a] = c_d; exp_wr.push_back({c_a, c_d}); end
               2'd2: begin v = mread(c_a); model_mem[c_b] = v; exp_wr.push_back({c_b, v}); end
               default: begin
                  for (int i = 0; i < int'(c_l); i++) begin
                     model_mem[AW'(c_a + AW'(i))] = c_d;
                     exp_wr.push_back({AW'(c_a + AW'(i)), c_d});
                  end
               end
            endcase
            have_cmd = 1'b0;
            accepted++;
         end
         if (rf_wen === 1'b1) begin
            wr_got = {rf_wsel, rf_wdat};
            checks++;
            if (exp_wr.size() == 0) begin errors++; $display("FAIL rnd_write unexpected sel=%h dat=%h", rf_wsel, rf_wdat); end
            else begin
               if (wr_got !== exp_wr[0]) begin errors++; $display("FAIL rnd_write got %h exp %h", wr_got, exp_wr[0]); end
               void'(exp_wr.pop_front());
            end
         end
         if (rsp_valid === 1'b1 && rsp_ready) begin
            rsp_got = {rsp_rdat1, rsp_rdat2};
            checks++;
            if (exp_rsp.size() == 0) begin errors++; $display("FAIL rnd_rsp unexpected %h", rsp_got); end
            else begin
               if (rsp_got !== exp_rsp[0]) begin errors++; $display("FAIL rnd_rsp got %h exp %h", rsp_got, exp_rsp[0]); end
               void'(exp_rsp.pop_front());
            end
         end
         tick();
         cyc++;
      end
      drive(1'b0, 2'd0, '0, '0, '0, '0);
      checks++; if (cyc >= BUDGET) begin errors++; $display("FAIL rnd_timeout got %0d cycles exp < %0d", cyc, BUDGET); end
      checks++; if (accepted != NCMD) begin errors++; $display("FAIL rnd_accepted got %0d exp %0d", accepted, NCMD); end
      checks++; if (exp_rsp.size() != 0 || exp_wr.size() != 0)
         begin errors++; $display("FAIL rnd_leftover got rsp=%0d wr=%0d exp 0/0", exp_rsp.size(), exp_wr.size()); end
      #3;
      checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_quiet got busy=%b rsp=%b exp 0/0", busy, rsp_valid); end
      tick();
   endtask

   initial begin
      rf_init = 1'b1;
      nRST = 1'b0;
      rsp_ready = 1'b1;
      drive(1'b0, 2'd0, '0, '0, '0, '0);
      tick();
      tick();
      rf_init = 1'b0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_copy();
      test_fill();
      test_reset_mid_fill();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_rf_access_sequencer
`default_nettype wire
